// File: rtl/multichannel_distortion_core_if.sv
// Bus bundle for multichannel_distortion_core: register port, input sample stream
// and output sample stream. The core connects through the slave modport.
interface multichannel_distortion_core_if #(
  parameter int DATA_W = 24,
  parameter int CH_W   = 1
);
  logic              cfg_write;
  logic              cfg_read;
  logic [4:0]        cfg_address;
  logic [31:0]       cfg_writedata;
  logic [31:0]       cfg_readdata;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic [CH_W-1:0]   s_chan;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [CH_W-1:0]   m_chan;

  modport master (
    output cfg_write, cfg_read, cfg_address, cfg_writedata,
    output s_valid, s_data, s_chan, m_ready,
    input  cfg_readdata, s_ready, m_valid, m_data, m_chan
  );

  modport slave (
    input  cfg_write, cfg_read, cfg_address, cfg_writedata,
    input  s_valid, s_data, s_chan, m_ready,
    output cfg_readdata, s_ready, m_valid, m_data, m_chan
  );
endinterface

// File: rtl/multichannel_distortion_core.sv
// Multi-channel gain + hard/soft clip with per-channel bypass and an output FIFO.
// Optional build macro CLIP_COUNTER_EN adds a clipped-sample counter at word 0x1F.
//
// state | meaning
// IDLE  | waiting for a sample; s_ready while ENABLE and FIFO has room
// MULT  | product of latched sample and gain, Q8.8 rescaled
// CLIP  | threshold clamp / soft knee, then saturation to DATA_W
// PUSH  | write {chan, y} into the output FIFO
module multichannel_distortion_core #(
  parameter int DATA_W     = 24,
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic clk_500,
  input  logic reset,
  multichannel_distortion_core_if.slave bus
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int PW   = DATA_W + 17;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MULT, CLIP, PUSH} state_t;

  state_t state_q, state_d;
  logic   s_ready_q, s_ready_d;

  logic                enable_q, enable_d, mode_q, clip_q;
  logic [CHANNELS-1:0] bypass_q;
  logic [15:0]         gain_q   [CHANNELS];
  logic [DATA_W-2:0]   thresh_q [CHANNELS];
  logic [31:0]         rdata_q, rd_val;

  logic [DATA_W-1:0]        sample_q;
  logic [CH_W-1:0]          chan_q, chan_sel;
  logic [15:0]              gain_l_q;
  logic [DATA_W-2:0]        thresh_l_q;
  logic                     byp_l_q, mode_l_q;
  logic signed [PW-1:0]     prod_q, prod_d, s_ext, g_ext;
  logic signed [PW-1:0]     t_w, mag_w, lim_w, val_w;
  logic [DATA_W-1:0]        y_q, y_d;
  logic                     clip_flag, clip_evt;

  logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
  logic [CH_W-1:0]   mem_chan_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              push, pop, hs;

  logic       wr_ctrl, wr_stat, ch_hit;
  logic [4:0] off;
  logic       unused_wdata;

`ifdef CLIP_COUNTER_EN
  logic [15:0] clip_cnt_q;
`endif

  assign unused_wdata = ^bus.cfg_writedata;

  assign wr_ctrl = bus.cfg_write && (bus.cfg_address == 5'h00);
  assign wr_stat = bus.cfg_write && (bus.cfg_address == 5'h01);
  assign off     = bus.cfg_address - 5'd2;
  assign ch_hit  = (bus.cfg_address >= 5'd2) && (int'(off[4:1]) < CHANNELS);
  assign enable_d = wr_ctrl ? bus.cfg_writedata[0] : enable_q;

  // Out-of-range channel tags fold onto channel 0.
  assign chan_sel = (int'(bus.s_chan) < CHANNELS) ? bus.s_chan : '0;
  assign hs       = (state_q == IDLE) && bus.s_valid && s_ready_q;

  assign push    = (state_q == PUSH);
  assign pop     = bus.m_ready && (count_q != '0);
  assign count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (hs) state_d = MULT;
      MULT: state_d = CLIP;
      CLIP: state_d = PUSH;
      PUSH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // s_ready is registered but computed from next-cycle values, so it tracks fill and ENABLE exactly.
  assign s_ready_d = (state_d == IDLE) && enable_d && (count_d < DEPTH_C);

  always_comb begin
    s_ext  = {{(PW-DATA_W){sample_q[DATA_W-1]}}, sample_q};
    g_ext  = {{(PW-16){1'b0}}, gain_l_q};
    prod_d = (s_ext * g_ext) >>> 8;
  end

  always_comb begin
    t_w       = {{(PW-DATA_W+1){1'b0}}, thresh_l_q};
    mag_w     = prod_q[PW-1] ? -prod_q : prod_q;
    lim_w     = t_w;
    val_w     = prod_q;
    clip_flag = 1'b0;
    if (mag_w > t_w) begin
      clip_flag = 1'b1;
      if (mode_l_q) lim_w = t_w + ((mag_w - t_w) >>> 2);
      val_w = prod_q[PW-1] ? -lim_w : lim_w;
    end
    y_d = val_w[DATA_W-1:0];
    if (val_w > SAT_MAX) begin
      y_d       = SAT_MAX[DATA_W-1:0];
      clip_flag = 1'b1;
    end else if (val_w < SAT_MIN) begin
      y_d       = SAT_MIN[DATA_W-1:0];
      clip_flag = 1'b1;
    end
    if (byp_l_q) begin
      y_d       = sample_q;
      clip_flag = 1'b0;
    end
  end

  assign clip_evt = (state_q == CLIP) && clip_flag;

  always_ff @(posedge clk_500 or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      s_ready_q  <= 1'b0;
      sample_q   <= '0;
      chan_q     <= '0;
      gain_l_q   <= '0;
      thresh_l_q <= '0;
      byp_l_q    <= 1'b0;
      mode_l_q   <= 1'b0;
      prod_q     <= '0;
      y_q        <= '0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= s_ready_d;
      case (state_q)
        IDLE: if (hs) begin
          sample_q   <= bus.s_data;
          chan_q     <= chan_sel;
          gain_l_q   <= gain_q[chan_sel];
          thresh_l_q <= thresh_q[chan_sel];
          byp_l_q    <= bypass_q[chan_sel];
          mode_l_q   <= mode_q;
        end
        MULT: prod_q <= prod_d;
        CLIP: y_q    <= y_d;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    case (bus.cfg_address)
      5'h00: begin
        rd_val[0]             = enable_q;
        rd_val[1]             = mode_q;
        rd_val[8 +: CHANNELS] = bypass_q;
      end
      5'h01: begin
        rd_val[0]       = (count_q == '0);
        rd_val[1]       = (count_q == DEPTH_C);
        rd_val[2]       = clip_q;
        rd_val[8 +: CW] = count_q;
      end
`ifdef CLIP_COUNTER_EN
      5'h1F: rd_val[15:0] = clip_cnt_q;
`endif
      default: begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (ch_hit && (int'(off[4:1]) == c)) begin
            if (off[0]) rd_val[DATA_W-2:0] = thresh_q[c];
            else        rd_val[15:0]       = gain_q[c];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_500 or negedge reset) begin
    if (!reset) begin
      enable_q <= 1'b0;
      mode_q   <= 1'b0;
      bypass_q <= '0;
      clip_q   <= 1'b0;
      rdata_q  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        gain_q[c]   <= 16'h0100;
        thresh_q[c] <= '1;
      end
    end else begin
      enable_q <= enable_d;
      if (wr_ctrl) begin
        mode_q   <= bus.cfg_writedata[1];
        bypass_q <= bus.cfg_writedata[8 +: CHANNELS];
      end
      // A clip on the same edge as a write-1-clear keeps the flag set.
      if (clip_evt)                               clip_q <= 1'b1;
      else if (wr_stat && bus.cfg_writedata[2])   clip_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        if (bus.cfg_write && ch_hit && (int'(off[4:1]) == c)) begin
          if (off[0]) thresh_q[c] <= bus.cfg_writedata[DATA_W-2:0];
          else        gain_q[c]   <= bus.cfg_writedata[15:0];
        end
      end
      if (bus.cfg_read) rdata_q <= rd_val;
    end
  end

`ifdef CLIP_COUNTER_EN
  always_ff @(posedge clk_500 or negedge reset) begin
    if (!reset)                                              clip_cnt_q <= '0;
    else if (bus.cfg_write && (bus.cfg_address == 5'h1F))    clip_cnt_q <= '0;
    else if (clip_evt && (clip_cnt_q != 16'hFFFF))           clip_cnt_q <= clip_cnt_q + 16'd1;
  end
`endif

  always_ff @(posedge clk_500 or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_chan_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (push) begin
        mem_data_q[wr_ptr_q] <= y_q;
        mem_chan_q[wr_ptr_q] <= chan_q;
        wr_ptr_q             <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign bus.s_ready      = s_ready_q;
  assign bus.cfg_readdata = rdata_q;
  assign bus.m_valid      = (count_q != '0);
  assign bus.m_data       = mem_data_q[rd_ptr_q];
  assign bus.m_chan       = mem_chan_q[rd_ptr_q];
endmodule

// File: tb/tb_multichannel_distortion_core.sv
// Directed bench for multichannel_distortion_core: register defaults, gain and
// clip modes, latency, FIFO backpressure, bypass, mid-flight changes, reset.
module tb_multichannel_distortion_core;
  logic clk_500 = 1'b0;
  logic reset   = 1'b0;
  int   errors  = 0;
  int   checks  = 0;

  multichannel_distortion_core_if #(.DATA_W(24), .CH_W(1)) bus ();

  multichannel_distortion_core #(.DATA_W(24), .CHANNELS(2), .FIFO_DEPTH(8)) dut (
    .clk_500 (clk_500),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_500 = ~clk_500;

  // All helpers start and end just after a falling edge.
  task automatic cfg_wr(input logic [4:0] a, input logic [31:0] d);
    bus.cfg_write = 1'b1; bus.cfg_address = a; bus.cfg_writedata = d;
    @(negedge clk_500);
    bus.cfg_write = 1'b0;
  endtask

  task automatic cfg_rd(input logic [4:0] a, output logic [31:0] d);
    bus.cfg_read = 1'b1; bus.cfg_address = a;
    @(negedge clk_500);
    bus.cfg_read = 1'b0;
    d = bus.cfg_readdata;
  endtask

  task automatic send(input logic ch, input logic [23:0] d, input int budget, output bit ok);
    ok = 1'b0;
    bus.s_valid = 1'b1; bus.s_data = d; bus.s_chan = ch;
    for (int k = 0; k < budget; k++) begin
      if (bus.s_ready) begin
        @(negedge clk_500);
        ok = 1'b1;
        break;
      end
      @(negedge clk_500);
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic recv(output logic [23:0] d, output logic ch, output bit ok);
    ok = 1'b0; d = 'x; ch = 'x;
    for (int k = 0; k < 20; k++) begin
      if (bus.m_valid) begin
        d = bus.m_data; ch = bus.m_chan;
        bus.m_ready = 1'b1;
        @(negedge clk_500);
        bus.m_ready = 1'b0;
        ok = 1'b1;
        break;
      end
      @(negedge clk_500);
    end
  endtask

  task automatic xfer(input logic ch, input logic [23:0] din, output logic [23:0] dout,
                      output logic cout, output bit ok);
    bit ok_s, ok_r;
    send(ch, din, 12, ok_s);
    recv(dout, cout, ok_r);
    ok = ok_s && ok_r;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    repeat (3) @(negedge clk_500);
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b want 0", bus.s_ready); end
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b want 0", bus.m_valid); end
    checks++; if (bus.m_data !== 24'h0) begin errors++; $display("FAIL rst_m_data: got %h want 000000", bus.m_data); end
    checks++; if (bus.cfg_readdata !== 32'h0) begin errors++; $display("FAIL rst_readdata: got %h want 0", bus.cfg_readdata); end
    reset = 1'b1;
    @(negedge clk_500);
    cfg_rd(5'h00, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_ctrl: got %h want 00000000", v); end
    cfg_rd(5'h01, v); checks++; if (v !== 32'h1) begin errors++; $display("FAIL rst_status: got %h want 00000001", v); end
    cfg_rd(5'h02, v); checks++; if (v !== 32'h100) begin errors++; $display("FAIL rst_gain0: got %h want 00000100", v); end
    cfg_rd(5'h03, v); checks++; if (v !== 32'h7FFFFF) begin errors++; $display("FAIL rst_thresh0: got %h want 007fffff", v); end
    cfg_rd(5'h05, v); checks++; if (v !== 32'h7FFFFF) begin errors++; $display("FAIL rst_thresh1: got %h want 007fffff", v); end
    cfg_rd(5'h10, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h want 0", v); end
    cfg_rd(5'h1F, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_clipcnt: got %h want 0", v); end
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready_after: got %b want 0", bus.s_ready); end
  endtask

  task automatic test_unity();
    logic [31:0] v; logic [23:0] d; logic c; bit ok;
    cfg_wr(5'h00, 32'h1);
    send(1'b1, 24'h001000, 12, ok);
    checks++; if (!ok) begin errors++; $display("FAIL unity_accept: got timeout want handshake"); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk_500);
      checks++;
      if (bus.m_valid !== (k == 3)) begin errors++; $display("FAIL latency_edge%0d: m_valid got %b want %b", k, bus.m_valid, (k == 3)); end
    end
    recv(d, c, ok);
    checks++; if (!ok || d !== 24'h001000 || c !== 1'b1) begin errors++; $display("FAIL unity_data: got %h ch%b want 001000 ch1", d, c); end
    cfg_rd(5'h01, v); checks++; if (v !== 32'h1) begin errors++; $display("FAIL unity_status: got %h want 00000001", v); end
  endtask

  task automatic test_hard_clip();
    logic [31:0] v; logic [23:0] d; logic c; bit ok;
    cfg_wr(5'h02, 32'h0400);
    cfg_wr(5'h03, 32'h010000);
    xfer(1'b0, 24'h008000, d, c, ok);
    checks++; if (!ok || d !== 24'h010000 || c !== 1'b0) begin errors++; $display("FAIL hard_pos: got %h ch%b want 010000 ch0", d, c); end
    cfg_rd(5'h01, v); checks++; if (v !== 32'h5) begin errors++; $display("FAIL hard_clip_set: got %h want 00000005", v); end
    cfg_wr(5'h01, 32'h4);
    cfg_rd(5'h01, v); checks++; if (v !== 32'h1) begin errors++; $display("FAIL clip_w1c: got %h want 00000001", v); end
    xfer(1'b0, 24'h002000, d, c, ok);
    checks++; if (!ok || d !== 24'h008000) begin errors++; $display("FAIL hard_below: got %h want 008000", d); end
    cfg_rd(5'h01, v); checks++; if (v !== 32'h1) begin errors++; $display("FAIL hard_noclip: got %h want 00000001", v); end
    xfer(1'b0, 24'hFF8000, d, c, ok);
    checks++; if (!ok || d !== 24'hFF0000) begin errors++; $display("FAIL hard_neg: got %h want ff0000", d); end
    cfg_wr(5'h04, 32'h0200);
    xfer(1'b1, 24'h600000, d, c, ok);
    checks++; if (!ok || d !== 24'h7FFFFF || c !== 1'b1) begin errors++; $display("FAIL hard_sat: got %h ch%b want 7fffff ch1", d, c); end
    cfg_wr(5'h04, 32'h0100);
  endtask

  task automatic test_soft_clip();
    logic [23:0] d; logic c; bit ok;
    cfg_wr(5'h00, 32'h3);
    xfer(1'b0, 24'h008000, d, c, ok);
    checks++; if (!ok || d !== 24'h014000) begin errors++; $display("FAIL soft_pos: got %h want 014000", d); end
    xfer(1'b0, 24'hFF8000, d, c, ok);
    checks++; if (!ok || d !== 24'hFEC000) begin errors++; $display("FAIL soft_neg: got %h want fec000", d); end
    cfg_wr(5'h02, 32'hFFFF);
    xfer(1'b0, 24'h7FFFFF, d, c, ok);
    checks++; if (!ok || d !== 24'h7FFFFF) begin errors++; $display("FAIL soft_sat: got %h want 7fffff", d); end
    xfer(1'b0, 24'hFF8000, d, c, ok);
    checks++; if (!ok || d !== 24'hDF4020) begin errors++; $display("FAIL soft_knee_neg: got %h want df4020", d); end
    cfg_wr(5'h02, 32'h0100);
    xfer(1'b0, 24'h001234, d, c, ok);
    checks++; if (!ok || d !== 24'h001234) begin errors++; $display("FAIL soft_below: got %h want 001234", d); end
    cfg_wr(5'h00, 32'h1);
    cfg_wr(5'h01, 32'h4);
  endtask

  task automatic test_backpressure();
    logic [31:0] v; logic [23:0] d, exp; logic c; bit ok; int accepted;
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      send(1'b1, 24'h000100 + 24'(i), 8, ok);
      if (ok) accepted++;
    end
    repeat (4) @(negedge clk_500);
    checks++; if (accepted != 8) begin errors++; $display("FAIL bp_accepted: got %0d want 8", accepted); end
    cfg_rd(5'h01, v); checks++; if (v !== 32'h0802) begin errors++; $display("FAIL bp_status_full: got %h want 00000802", v); end
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready: got %b want 0", bus.s_ready); end
    recv(d, c, ok);
    checks++; if (!ok || d !== 24'h000100) begin errors++; $display("FAIL bp_first_pop: got %h want 000100", d); end
    send(1'b1, 24'h000200, 8, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_refill: got timeout want handshake"); end
    for (int i = 0; i < 8; i++) begin
      exp = (i < 7) ? 24'h000101 + 24'(i) : 24'h000200;
      recv(d, c, ok);
      checks++; if (!ok || d !== exp || c !== 1'b1) begin errors++; $display("FAIL bp_order%0d: got %h ch%b want %h ch1", i, d, c, exp); end
    end
    cfg_rd(5'h01, v); checks++; if (v !== 32'h1) begin errors++; $display("FAIL bp_drained: got %h want 00000001", v); end
  endtask

  task automatic test_bypass();
    logic [31:0] v; logic [23:0] d; logic c; bit ok;
    cfg_wr(5'h02, 32'h0400);
    cfg_wr(5'h00, 32'h101);
    cfg_rd(5'h00, v); checks++; if (v !== 32'h101) begin errors++; $display("FAIL byp_ctrl_rb: got %h want 00000101", v); end
    xfer(1'b0, 24'h008000, d, c, ok);
    checks++; if (!ok || d !== 24'h008000) begin errors++; $display("FAIL byp_pos: got %h want 008000", d); end
    xfer(1'b0, 24'h800000, d, c, ok);
    checks++; if (!ok || d !== 24'h800000) begin errors++; $display("FAIL byp_min: got %h want 800000", d); end
    cfg_rd(5'h01, v); checks++; if (v !== 32'h1) begin errors++; $display("FAIL byp_noclip: got %h want 00000001", v); end
    xfer(1'b1, 24'h000800, d, c, ok);
    checks++; if (!ok || d !== 24'h000800 || c !== 1'b1) begin errors++; $display("FAIL byp_other_ch: got %h ch%b want 000800 ch1", d, c); end
  endtask

  task automatic test_midflight();
    logic [23:0] d; logic c; bit ok;
    cfg_wr(5'h00, 32'h1);
    cfg_wr(5'h02, 32'h0200);
    cfg_wr(5'h03, 32'h7FFFFF);
    send(1'b0, 24'h001000, 12, ok);
    cfg_wr(5'h02, 32'h0400);
    recv(d, c, ok);
    checks++; if (!ok || d !== 24'h002000) begin errors++; $display("FAIL mid_old_gain: got %h want 002000", d); end
    xfer(1'b0, 24'h001000, d, c, ok);
    checks++; if (!ok || d !== 24'h004000) begin errors++; $display("FAIL mid_new_gain: got %h want 004000", d); end
    send(1'b0, 24'h000100, 12, ok);
    cfg_wr(5'h00, 32'h0);
    recv(d, c, ok);
    checks++; if (!ok || d !== 24'h000400) begin errors++; $display("FAIL disable_inflight: got %h want 000400", d); end
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL disable_s_ready: got %b want 0", bus.s_ready); end
    send(1'b0, 24'h000055, 8, ok);
    checks++; if (ok) begin errors++; $display("FAIL disable_accept: got handshake want none"); end
  endtask

  task automatic test_clip_counter();
    logic [31:0] v; logic [23:0] d; logic c; bit ok;
`ifdef CLIP_COUNTER_EN
    cfg_wr(5'h00, 32'h1);
    cfg_wr(5'h03, 32'h010000);
    cfg_wr(5'h1F, 32'h0);
    for (int i = 0; i < 3; i++) xfer(1'b0, 24'h008000, d, c, ok);
    xfer(1'b0, 24'h000100, d, c, ok);
    cfg_rd(5'h1F, v); checks++; if (v !== 32'h3) begin errors++; $display("FAIL clipcnt_3: got %h want 00000003", v); end
    cfg_wr(5'h1F, 32'h1234);
    cfg_rd(5'h1F, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL clipcnt_clear: got %h want 0", v); end
`else
    cfg_wr(5'h00, 32'h1);
    xfer(1'b0, 24'h008000, d, c, ok);
    cfg_wr(5'h1F, 32'hFFFF);
    cfg_rd(5'h1F, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL clipcnt_absent: got %h want 0", v); end
`endif
  endtask

  task automatic test_reset_midop();
    logic [31:0] v; bit ok;
    cfg_wr(5'h00, 32'h1);
    send(1'b0, 24'h000011, 12, ok);
    send(1'b0, 24'h000022, 12, ok);
    send(1'b0, 24'h000033, 12, ok);
    reset = 1'b0;
    #1;
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL midrst_m_valid: got %b want 0", bus.m_valid); end
    @(negedge clk_500);
    reset = 1'b1;
    repeat (5) @(negedge clk_500);
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL midrst_inflight: got %b want 0", bus.m_valid); end
    cfg_rd(5'h01, v); checks++; if (v !== 32'h1) begin errors++; $display("FAIL midrst_status: got %h want 00000001", v); end
    cfg_rd(5'h02, v); checks++; if (v !== 32'h100) begin errors++; $display("FAIL midrst_gain: got %h want 00000100", v); end
    cfg_rd(5'h00, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL midrst_ctrl: got %h want 0", v); end
  endtask

  initial begin
    bus.cfg_write = 1'b0; bus.cfg_read = 1'b0; bus.cfg_address = '0; bus.cfg_writedata = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_chan = '0; bus.m_ready = 1'b0;
    test_reset();
    test_unity();
    test_hard_clip();
    test_soft_clip();
    test_backpressure();
    test_bypass();
    test_midflight();
    test_clip_counter();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/multichannel_distortion_core.md
Name: multichannel_distortion_core

Overview:
- Parametrised, multi-channel successor to the single-channel distortion path.
- Accepts channel-tagged signed audio samples on a valid/ready stream and applies per-channel gain and hard or soft clipping, with per-channel bypass.
- Results are buffered in an internal output FIFO and exposed on a valid/ready stream.
- Configured through a small word-addressed register port. Sits between the Avalon-facing sample FIFOs and the codec side, entirely in the clk_500 domain.

Parameters:
DATA_W, 24, sample width, signed two's complement
CHANNELS, 2, number of channels, 1..8
FIFO_DEPTH, 8, output FIFO entries, power of two, 2..64
CH_W, derived max(1,$clog2(CHANNELS)), channel tag width

Ports:
clk_500  in  1  processing clock
reset  in  1  asynchronous, active-low
cfg_write  in  1  register write strobe
cfg_read  in  1  register read strobe
cfg_address  in  5  word address
cfg_writedata  in  32  write data
cfg_readdata  out  32  read data, registered
s_valid  in  1  input sample valid
s_ready  out  1  input sample accepted when s_valid&&s_ready
s_data  in  DATA_W  input sample
s_chan  in  CH_W  input channel tag
m_valid  out  1  FIFO not empty
m_ready  in  1  consumer pops when m_valid&&m_ready
m_data  out  DATA_W  FIFO head sample
m_chan  out  CH_W  FIFO head channel tag

Behaviour:
- Clocking/reset: reset is asynchronous, active-low; clock is clk_500.
- Reset values:
  - Outputs: cfg_readdata=0, s_ready=0, m_valid=0, m_data=0, m_chan=0.
  - State: FIFO empty, FSM=IDLE.
  - Registers: CTRL=0, GAIN[c]=0x0100 (unity), THRESH[c]=2^(DATA_W-1)-1, sticky CLIP=0.
- Register map (word addresses):
  - 0x00 CTRL RW: bit0 ENABLE; bit1 MODE (0=hard, 1=soft); bits[8+CHANNELS-1:8] per-channel BYPASS.
  - 0x01 STATUS: bit0 empty (RO); bit1 full (RO); bit2 sticky CLIP (write 1 clears); bits[15:8] FIFO fill level (RO).
  - 0x02+2c GAIN[c] RW: unsigned Q8.8 in bits[15:0].
  - 0x03+2c THRESH[c] RW: unsigned, bits[DATA_W-2:0].
  - Unmapped addresses read 0; writes to them are ignored. s_chan>=CHANNELS is treated as channel 0.
- Register port timing:
  - cfg_readdata updates on the clock after cfg_read and holds until the next read.
  - cfg_write takes effect on that edge.
  - Simultaneous cfg_read and cfg_write to the same address return the old value.
- FSM: IDLE -> MULT -> CLIP -> PUSH -> IDLE, one state per cycle.
  - IDLE: s_ready = ENABLE && fill<FIFO_DEPTH. On handshake, latch sample, channel, and that channel's GAIN/THRESH/BYPASS plus MODE; go to MULT.
  - Config changes after acceptance do not affect the in-flight sample.
  - MULT: p = (s * gain) >>> 8 (arithmetic shift), full width DATA_W+17.
  - CLIP, with t=THRESH:
    - Hard: clamp p to [-t, +t].
    - Soft: if |p|>t, y = sign*(t + ((|p|-t)>>2)), else y=p.
    - Both modes: finally saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
    - Any clamp or saturation sets sticky CLIP.
  - Bypass: y = latched sample; CLIP is not set; latency is unchanged.
  - PUSH: write {chan,y} into the FIFO.
- Latency and throughput:
  - Handshake at edge N -> FIFO write at edge N+3 -> m_valid high after edge N+3.
  - Throughput is 1 sample per 4 cycles; s_ready is low outside IDLE.
- FIFO:
  - m_data/m_chan show the head combinationally from registered storage.
  - Simultaneous push and pop is allowed at any fill, including full.
  - Overflow is impossible, because acceptance requires fill<FIFO_DEPTH and nothing else is in flight.
  - Pop when empty is ignored.
- ENABLE cleared mid-sample: the in-flight sample completes and is pushed; no further accepts. The FIFO continues to drain.
- Reset asserted mid-operation: the in-flight sample and FIFO contents are discarded immediately.

Optional Feature:
- Macro: CLIP_COUNTER_EN.
- Defined: a 16-bit saturating counter of clipped samples, all channels combined, readable at 0x1F. Any write to 0x1F clears it. An increment on the same edge as a clear results in 0.
- Undefined: 0x1F reads 0 and writes are ignored. The sticky CLIP bit exists in both builds.

Test Plan:
- Reset defaults: after reset release, reads of 0x00/0x01/0x02/0x03 -> 0, 0x1 (empty), 0x0100, 0x7FFFFF; s_ready=0.
- Unity path: CTRL=1; push ch1 sample 0x001000 -> m_valid 3 edges after handshake, m_data=0x001000, m_chan=1, CLIP=0.
- Hard clip: GAIN[0]=0x0400, THRESH[0]=0x010000, sample 0x008000 -> 0x010000, CLIP=1; sample 0xFF8000 -> 0xFF0000.
- Soft clip: MODE=1, same settings, sample 0x008000 (p=0x020000) -> 0x014000; GAIN=0xFFFF, sample 0x7FFFFF -> 0x7FFFFF saturated.
- Backpressure: m_ready=0, feed 10 samples, FIFO_DEPTH=8 -> exactly 8 accepted, STATUS full=1, s_ready=0; one pop -> one more accepted; order preserved.
- Bypass and mid-flight changes: BYPASS ch0 with GAIN=0x0400 -> output equals input. Write GAIN during MULT -> that sample uses the old gain. With CLIP_COUNTER_EN, 3 clipped samples -> 0x1F reads 3; a write clears it to 0.
